// File: rtl/headstage_pkg.sv
// Shared headstage constants and the frame-builder FSM encoding.
// The SPI master uses the same FRAME_W and ID_W, so both sides agree on the payload shape.
package headstage_pkg;

   localparam int unsigned N_CH     = 32;
   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned N_SETS   = 2;
   localparam int unsigned ID_W     = 8;
   localparam int unsigned FRAME_W  = N_CH * SAMPLE_W * N_SETS;
   localparam int unsigned DROP_W   = 16;

   localparam int unsigned CH_W     = $clog2(N_CH);
   localparam int unsigned SET_W    = $clog2(N_SETS);
   localparam int unsigned N_SLOTS  = N_CH * N_SETS;
   localparam int unsigned SLOT_W   = SET_W + CH_W;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSync = 2'd1,
      StFill = 2'd2
   } build_state_e;

endpackage

// File: rtl/spi_frame_builder.sv
// Packs per-channel ADC samples into one FRAME_W-bit payload of N_SETS full channel scans and
// publishes it with an incrementing frame ID.
// Ports:
//   clk_160mhz    system clock
//   rst           synchronous active-high reset
//   build_en      assembly enable; low returns to idle and discards a partial frame
//   sample_valid  sample strobe, at most one sample per cycle
//   sample_ch     channel index of the sample
//   sample_data   sample value
//   frame         last published frame (first sample at the MSBs)
//   spi_frame_id  ID of frame, changes only together with frame
//   frame_pulse   one-cycle pulse when frame/spi_frame_id update
//   seq_err       one-cycle pulse on a channel-order violation
//   drop_cnt      saturating count of discarded partial frames
module spi_frame_builder
   import headstage_pkg::*;
(
   input  logic                clk_160mhz,
   input  logic                rst,
   input  logic                build_en,
   input  logic                sample_valid,
   input  logic [CH_W-1:0]     sample_ch,
   input  logic [SAMPLE_W-1:0] sample_data,
   output logic [FRAME_W-1:0]  frame,
   output logic [ID_W-1:0]     spi_frame_id,
   output logic                frame_pulse,
   output logic                seq_err,
   output logic [DROP_W-1:0]   drop_cnt
);

   build_state_e       state_q;
   logic [CH_W-1:0]    exp_ch_q;
   logic [SET_W-1:0]   set_idx_q;
   logic [FRAME_W-1:0] asm_q;
   logic [FRAME_W-1:0] asm_d;

   logic              smp;
   logic              ch_match;
   logic              accept;
   logic              start;
   logic              last;
   logic              mismatch;
   logic              partial;
   logic              drop_inc;
   logic              wr_en;
   logic [SLOT_W-1:0] wr_slot;

   always_comb begin
      smp      = build_en && sample_valid;
      ch_match = (sample_ch == exp_ch_q);
      accept   = smp && (state_q == StFill) && ch_match;
      mismatch = smp && (state_q == StFill) && !ch_match;
      // A ch0 sample opens a new frame from SYNC, or restarts one after a FILL order error.
      start    = smp && (sample_ch == '0) && ((state_q == StSync) || mismatch);
      last     = accept && (set_idx_q == SET_W'(N_SETS - 1)) && (exp_ch_q == CH_W'(N_CH - 1));
      // exp_ch/set_idx both return to zero after a publish, so nonzero means samples are held.
      partial  = (state_q == StFill) && ((exp_ch_q != '0) || (set_idx_q != '0));
      drop_inc = mismatch || (!build_en && partial);
      wr_en    = accept || start;
      wr_slot  = start ? '0 : {set_idx_q, exp_ch_q};
   end

   // Per-slot write decoder; asm_d also feeds frame so the final sample is merged on publish.
   always_comb begin
      asm_d = asm_q;
      for (int s = 0; s < N_SLOTS; s++) begin
         if (wr_en && (wr_slot == SLOT_W'(s))) begin
            asm_d[FRAME_W - 1 - s * SAMPLE_W -: SAMPLE_W] = sample_data;
         end
      end
   end

   always_ff @(posedge clk_160mhz) begin
      if (rst) begin
         state_q      <= StIdle;
         exp_ch_q     <= '0;
         set_idx_q    <= '0;
         asm_q        <= '0;
         frame        <= '0;
         spi_frame_id <= '0;
         frame_pulse  <= 1'b0;
         seq_err      <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         frame_pulse <= 1'b0;
         seq_err     <= 1'b0;
         asm_q       <= asm_d;

         if (drop_inc && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end

         if (!build_en) begin
            state_q   <= StIdle;
            exp_ch_q  <= '0;
            set_idx_q <= '0;
         end else begin
            unique case (state_q)
               StIdle: state_q <= StSync;
               StSync: begin
                  if (start) begin
                     exp_ch_q  <= CH_W'(1);
                     set_idx_q <= '0;
                     state_q   <= StFill;
                  end
               end
               StFill: begin
                  if (accept) begin
                     exp_ch_q <= exp_ch_q + 1'b1;
                     if (exp_ch_q == CH_W'(N_CH - 1)) begin
                        set_idx_q <= set_idx_q + 1'b1;
                     end
                     if (last) begin
                        frame        <= asm_d;
                        spi_frame_id <= spi_frame_id + 1'b1;
                        frame_pulse  <= 1'b1;
                     end
                  end else if (mismatch) begin
                     seq_err <= 1'b1;
                     if (start) begin
                        exp_ch_q  <= CH_W'(1);
                        set_idx_q <= '0;
                     end else begin
                        state_q <= StSync;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
